// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared defaults and FSM state type for the SRAM arbiter
// Contents:
//   SRAM_ADDR_W / SRAM_DATA_W / SRAM_ACC_CYC : default geometry and access length
//   state_t                                  : arbiter FSM states
package sram_pkg;

  localparam int SRAM_ADDR_W  = 20;
  localparam int SRAM_DATA_W  = 16;
  localparam int SRAM_ACC_CYC = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-port round-robin grant decision (combinational)
// Ports:
//   req  [1:0] in  : request per port
//   last       in  : index of the port served most recently
//   gnt  [1:0] out : one-hot grant, zero when nobody requests
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Tie: the port that was not served last goes next.
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter for an asynchronous SRAM
// Ports:
//   clk, i_rst                      : clock, async active-high reset
//   i_req*/i_we*/i_addr*/i_wdata*   : port 0 (frame loader) / port 1 (color transform) request
//   o_ack*/o_rdata*                 : one-cycle completion pulse and read data per port
//   o_busy                          : FSM not in IDLE
//   oSRAM_ADDR, ioSRAM_DQ           : SRAM address and bidirectional data
//   oSRAM_WE_N/OE_N/CE_N            : active-low SRAM strobes
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W,
  parameter int ACC_CYC = SRAM_ACC_CYC
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_busy,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  inout  wire  [DATA_W-1:0] ioSRAM_DQ,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_CE_N
);

  state_t state, state_next;

  logic [3:0]        cnt;
  logic              last;      // port served most recently
  logic              port_q;    // port owning the current access
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic [1:0] gnt;
  logic       grant_any;
  logic       grant_port;

  rr_arb2 u_rr_arb2 (
    .req  ({i_req1, i_req0}),
    .last (last),
    .gnt  (gnt)
  );

  assign grant_any  = |gnt;
  assign grant_port = gnt[1];

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt      <= 4'd0;
      last     <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            port_q  <= grant_port;
            last    <= grant_port;
            we_q    <= grant_port ? i_we1    : i_we0;
            addr_q  <= grant_port ? i_addr1  : i_addr0;
            wdata_q <= grant_port ? i_wdata1 : i_wdata0;
            cnt     <= 4'(ACC_CYC - 1);
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!we_q) begin
            // Last access cycle: SRAM output has settled for ACC_CYC cycles.
            if (port_q) rdata1_q <= ioSRAM_DQ;
            else        rdata0_q <= ioSRAM_DQ;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state register so reset releases them at once.
  assign oSRAM_CE_N = !(state == ACCESS);
  assign oSRAM_OE_N = !(state == ACCESS && !we_q);
  assign oSRAM_WE_N = !(state == ACCESS && we_q);
  assign oSRAM_ADDR = addr_q;
  assign ioSRAM_DQ  = (state == ACCESS && we_q) ? wdata_q : {DATA_W{1'bz}};

  assign o_busy   = (state != IDLE);
  assign o_ack0   = (state == ACK) && !port_q;
  assign o_ack1   = (state == ACK) &&  port_q;
  assign o_rdata0 = rdata0_q;
  assign o_rdata1 = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a behavioural SRAM
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_req0, i_req1, i_we0, i_we1;
  logic [19:0] i_addr0, i_addr1;
  logic [15:0] i_wdata0, i_wdata1;
  logic        o_ack0, o_ack1, o_busy;
  logic [15:0] o_rdata0, o_rdata1;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        we_n, oe_n, ce_n;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACC_CYC(2)) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_req0     (i_req0),
    .i_req1     (i_req1),
    .i_we0      (i_we0),
    .i_we1      (i_we1),
    .i_addr0    (i_addr0),
    .i_addr1    (i_addr1),
    .i_wdata0   (i_wdata0),
    .i_wdata1   (i_wdata1),
    .o_ack0     (o_ack0),
    .o_ack1     (o_ack1),
    .o_rdata0   (o_rdata0),
    .o_rdata1   (o_rdata1),
    .o_busy     (o_busy),
    .oSRAM_ADDR (sram_addr),
    .ioSRAM_DQ  (sram_dq),
    .oSRAM_WE_N (we_n),
    .oSRAM_OE_N (oe_n),
    .oSRAM_CE_N (ce_n)
  );

  // Behavioural SRAM: 256 words, drives DQ only while output-enabled.
  logic [15:0] mem [0:255];
  assign sram_dq = (!oe_n && !ce_n) ? mem[sram_addr[7:0]] : 16'bz;
  always @(posedge clk) if (!we_n && !ce_n) mem[sram_addr[7:0]] = sram_dq;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        port;
    logic        is_read;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        seen0, seen1;
  int          acks0, acks1;
  int          we_low_cnt;
  logic [15:0] exp_dq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and run the output monitor there.
  task automatic step();
    exp_t e;
    @(negedge clk);
    seen0 = o_ack0;
    seen1 = o_ack1;
    check("oe_we_both_low", 32'(!oe_n && !we_n), 32'd0);
    if (!we_n) begin
      we_low_cnt++;
      check("dq_write", 32'(sram_dq), 32'(exp_dq));
    end
    if (o_ack0 || o_ack1) begin
      check("ack_exclusive", 32'(o_ack0 & o_ack1), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'({o_ack1, o_ack0}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_port", 32'(o_ack1), 32'(e.port));
        check("ack_cycle", 32'(cyc), 32'(e.due));
        if (e.is_read) check("rdata", 32'(e.port ? o_rdata1 : o_rdata0), 32'(e.data));
        if (o_ack1) acks1++;
        else        acks0++;
      end
    end
  endtask

  // Drive a request in the next (idle) cycle; optionally expect its ack ACC_CYC+1 cycles later.
  task automatic start_access(input logic port, input logic we, input logic [19:0] addr,
                              input logic [15:0] wdata, input logic [15:0] exp_rd,
                              input logic push);
    exp_t e;
    step();
    if (push) begin
      e.port = port; e.is_read = !we; e.data = exp_rd; e.due = cyc + 3;
      sb.push_back(e);
    end
    if (port) begin
      i_req1 = 1'b1; i_we1 = we; i_addr1 = addr; i_wdata1 = wdata;
    end else begin
      i_req0 = 1'b1; i_we0 = we; i_addr0 = addr; i_wdata0 = wdata;
    end
  endtask

  task automatic wait_ack(input logic port);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      got = port ? seen1 : seen0;
    end
    if (port) i_req1 = 1'b0;
    else      i_req0 = 1'b0;
    if (!got) check("ack_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    exp_t e;
    logic done;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[5] = 16'hBEEF;
    mem[2] = 16'h2222;
    mem[3] = 16'h3333;
    i_rst = 1'b1;
    i_req0 = 0; i_req1 = 0; i_we0 = 0; i_we1 = 0;
    i_addr0 = '0; i_addr1 = '0; i_wdata0 = '0; i_wdata1 = '0;
    acks0 = 0; acks1 = 0; we_low_cnt = 0; exp_dq = 16'h0000;

    // Reset state
    step();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_acks", 32'({o_ack1, o_ack0}), 32'd0);
    check("rst_strobes", 32'({we_n, oe_n, ce_n}), 32'b111);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_rdata0", 32'(o_rdata0), 32'd0);
    check("rst_rdata1", 32'(o_rdata1), 32'd0);
    i_rst = 1'b0;

    // Single read on port 1
    start_access(1'b1, 1'b0, 20'd5, 16'h0, 16'hBEEF, 1'b1);
    step();
    check("busy_access", 32'(o_busy), 32'd1);
    check("addr_access", 32'(sram_addr), 32'd5);
    wait_ack(1'b1);

    // Single write on port 0, then read back
    exp_dq = 16'h1234;
    we_low_cnt = 0;
    start_access(1'b0, 1'b1, 20'h00010, 16'h1234, 16'h0, 1'b1);
    wait_ack(1'b0);
    check("we_low_cycles", 32'(we_low_cnt), 32'd2);
    check("mem_after_write", 32'(mem[8'h10]), 32'h1234);
    start_access(1'b0, 1'b0, 20'h00010, 16'h0, 16'h1234, 1'b1);
    wait_ack(1'b0);
    check("rdata1_hold", 32'(o_rdata1), 32'hBEEF);

    // Contention from reset: both ports request continuously
    i_rst = 1'b1;
    step();
    i_req0 = 1; i_we0 = 0; i_addr0 = 20'd2;
    i_req1 = 1; i_we1 = 0; i_addr1 = 20'd3;
    acks0 = 0; acks1 = 0;
    for (int k = 0; k < 8; k++) begin
      e.port = k[0]; e.is_read = 1'b1; e.data = k[0] ? 16'h3333 : 16'h2222;
      e.due = cyc + 3 + 4 * k;
      sb.push_back(e);
    end
    i_rst = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (acks0 + acks1 == 8) done = 1'b1;
    end
    i_req0 = 0; i_req1 = 0;
    if (!done) check("contention_timeout", 32'd1, 32'd0);
    check("contention_acks0", 32'(acks0), 32'd4);
    check("contention_acks1", 32'(acks1), 32'd4);

    // Reset asserted on the first access cycle of a write
    exp_dq = 16'h5678;
    start_access(1'b0, 1'b1, 20'h00020, 16'h5678, 16'h0, 1'b0);
    step();
    check("midrst_we_low", 32'(we_n), 32'd0);
    i_rst = 1'b1;
    i_req0 = 1'b0;
    #1;
    check("midrst_strobes", 32'({we_n, oe_n, ce_n}), 32'b111);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_addr", 32'(sram_addr), 32'd0);
    check("midrst_rdata0", 32'(o_rdata0), 32'd0);
    repeat (3) step();
    i_rst = 1'b0;
    repeat (6) step();
    check("midrst_mem", 32'(mem[8'h20]), 32'd0);

    // Abandoned port-0 pulse while port 1 is in ACCESS
    acks0 = 0;
    start_access(1'b1, 1'b0, 20'd5, 16'h0, 16'hBEEF, 1'b1);
    step();
    i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 20'd2;
    step();
    i_req0 = 1'b0;
    wait_ack(1'b1);
    step();
    check("busy_after_ack", 32'(o_busy), 32'd0);
    repeat (6) step();
    check("abandoned_acks0", 32'(acks0), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
